// File: rtl/m_store_buf.sv
// m_store_buf
// Store path for the M stage. It turns a right-justified store into byte
// enables and lane-positioned write data for a DATA_W-wide memory, queues
// accepted stores in a DEPTH-entry FIFO and drains the head entry to data
// memory over a valid/ready handshake. Misaligned stores are dropped and
// reported with a one-cycle align_err pulse and a captured err_addr.
// With MERGE=1, a store to the same memory word as the tail entry is folded
// into that entry when the tail is not also the head.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   st_valid / st_ready   store request handshake (st_ready = not full)
//   st_size               log2 of access bytes (0 byte .. 3 dword)
//   st_addr, st_data      byte address, right-justified store data
//   mem_valid / mem_ready head entry handshake towards data memory
//   mem_addr              lane-aligned address of the head entry
//   mem_byteen, mem_wdata head entry byte enables and positioned data
//   count                 number of occupied entries
//   align_err, err_addr   misalignment pulse and last misaligned address
module m_store_buf #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4,
  parameter int MERGE  = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       st_valid,
  output logic                       st_ready,
  input  logic [1:0]                 st_size,
  input  logic [ADDR_W-1:0]          st_addr,
  input  logic [DATA_W-1:0]          st_data,
  output logic                       mem_valid,
  input  logic                       mem_ready,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W/8-1:0]        mem_byteen,
  output logic [DATA_W-1:0]          mem_wdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       align_err,
  output logic [ADDR_W-1:0]          err_addr
);

  localparam int LANES = DATA_W / 8;
  localparam int OFF_W = $clog2(LANES);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] ent_addr [DEPTH];
  logic [LANES-1:0]  ent_be   [DEPTH];
  logic [DATA_W-1:0] ent_data [DEPTH];

  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [PTR_W-1:0]  last;

  logic [OFF_W-1:0]  off;
  logic [3:0]        nb;
  logic              misaligned;
  logic [ADDR_W-1:0] waddr;
  logic [LANES-1:0]  be;
  logic [DATA_W-1:0] dmask;
  logic [DATA_W-1:0] bmask;
  logic [DATA_W-1:0] wdata;
  logic              merge_hit;
  logic              accept;
  logic              alloc;
  logic              drain;

  // Decode the incoming store into lane enables and positioned data.
  // Data is first trimmed to the access size so unused lanes carry zero,
  // which lets a merge simply OR the new bytes over a cleared hole.
  always_comb begin
    off        = st_addr[OFF_W-1:0];
    nb         = 4'd1 << st_size;
    misaligned = (32'(nb) > 32'(LANES)) ||
                 ((32'(off) & (32'(nb) - 32'd1)) != 32'd0);
    waddr      = {st_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    be         = '0;
    dmask      = '0;
    bmask      = '0;
    for (int i = 0; i < LANES; i++) begin
      if ((i >= int'(off)) && (i < int'(off) + int'(nb))) begin
        be[i] = 1'b1;
      end
      if (i < int'(nb)) begin
        dmask[8*i +: 8] = 8'hFF;
      end
    end
    for (int i = 0; i < LANES; i++) begin
      bmask[8*i +: 8] = {8{be[i]}};
    end
    wdata = (st_data & dmask) << {off, 3'b000};
  end

  // The tail entry is the one most recently allocated. Requiring two or
  // more entries guarantees it is not the head, so it can never be the
  // entry leaving towards memory in the same cycle.
  always_comb begin
    last      = tail - PTR_W'(1);
    st_ready  = (count != CNT_W'(DEPTH));
    mem_valid = (count != '0);
    merge_hit = (MERGE != 0) && (count >= CNT_W'(2)) && (ent_addr[last] == waddr);
    accept    = st_valid && st_ready && !misaligned;
    alloc     = accept && !merge_hit;
    drain     = mem_valid && mem_ready;
    mem_addr   = mem_valid ? ent_addr[head] : '0;
    mem_byteen = mem_valid ? ent_be[head]   : '0;
    mem_wdata  = mem_valid ? ent_data[head] : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      align_err <= 1'b0;
      err_addr  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr[i] <= '0;
        ent_be[i]   <= '0;
        ent_data[i] <= '0;
      end
    end else begin
      align_err <= st_valid && misaligned;
      if (st_valid && misaligned) begin
        err_addr <= st_addr;
      end
      if (alloc) begin
        ent_addr[tail] <= waddr;
        ent_be[tail]   <= be;
        ent_data[tail] <= wdata;
        tail           <= tail + PTR_W'(1);
      end
      if (accept && merge_hit) begin
        ent_be[last]   <= ent_be[last] | be;
        ent_data[last] <= (ent_data[last] & ~bmask) | wdata;
      end
      if (drain) begin
        head <= head + PTR_W'(1);
      end
      // A merge never changes occupancy; alloc and drain together cancel.
      case ({alloc, drain})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_m_store_buf.sv
// tb_m_store_buf
// Self-checking bench for m_store_buf. Three instances share one stimulus
// stream: a 32-bit buffer without merging, a 32-bit buffer with merging and
// a 64-bit, 8-deep buffer with merging. Each has its own reference model,
// kept as an ordered list of pending entries where index 0 is the next
// entry memory will see. Directed sequences come first, then random
// traffic around a small address window so merges, fills and errors occur.
module tb_m_store_buf;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [1:0]  st_size;
  logic [31:0] st_addr;
  logic [63:0] st_data;
  logic        mem_ready;

  logic        rdy_a, mv_a, ae_a;
  logic [31:0] ma_a, ea_a, md_a;
  logic [3:0]  be_a;
  logic [2:0]  cnt_a;

  logic        rdy_b, mv_b, ae_b;
  logic [31:0] ma_b, ea_b, md_b;
  logic [3:0]  be_b;
  logic [2:0]  cnt_b;

  logic        rdy_c, mv_c, ae_c;
  logic [31:0] ma_c, ea_c;
  logic [63:0] md_c;
  logic [7:0]  be_c;
  logic [3:0]  cnt_c;

  int n_compared   = 0;
  int n_mismatched = 0;

  int          mcnt  [3];
  logic [31:0] qaddr [3][8];
  logic [7:0]  qbe   [3][8];
  logic [63:0] qdat  [3][8];
  logic        qerr  [3];
  logic [31:0] qerra [3];

  always #5 clk = ~clk;

  m_store_buf #(.DATA_W(32), .ADDR_W(32), .DEPTH(4), .MERGE(0)) dut_a (
    .clk(clk), .reset(reset), .st_valid(st_valid), .st_ready(rdy_a),
    .st_size(st_size), .st_addr(st_addr), .st_data(st_data[31:0]),
    .mem_valid(mv_a), .mem_ready(mem_ready), .mem_addr(ma_a),
    .mem_byteen(be_a), .mem_wdata(md_a), .count(cnt_a),
    .align_err(ae_a), .err_addr(ea_a));

  m_store_buf #(.DATA_W(32), .ADDR_W(32), .DEPTH(4), .MERGE(1)) dut_b (
    .clk(clk), .reset(reset), .st_valid(st_valid), .st_ready(rdy_b),
    .st_size(st_size), .st_addr(st_addr), .st_data(st_data[31:0]),
    .mem_valid(mv_b), .mem_ready(mem_ready), .mem_addr(ma_b),
    .mem_byteen(be_b), .mem_wdata(md_b), .count(cnt_b),
    .align_err(ae_b), .err_addr(ea_b));

  m_store_buf #(.DATA_W(64), .ADDR_W(32), .DEPTH(8), .MERGE(1)) dut_c (
    .clk(clk), .reset(reset), .st_valid(st_valid), .st_ready(rdy_c),
    .st_size(st_size), .st_addr(st_addr), .st_data(st_data),
    .mem_valid(mv_c), .mem_ready(mem_ready), .mem_addr(ma_c),
    .mem_byteen(be_c), .mem_wdata(md_c), .count(cnt_c),
    .align_err(ae_c), .err_addr(ea_c));

  function automatic int lanes_of(input int k);
    return (k == 2) ? 8 : 4;
  endfunction

  function automatic int depth_of(input int k);
    return (k == 2) ? 8 : 4;
  endfunction

  function automatic bit merge_of(input int k);
    return (k != 0);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance the reference model of instance k by one clock using the
  // inputs currently driven and the pre-edge model contents.
  task automatic model_step(input int k);
    int          lanes, nb, off, tl;
    logic        mis, acc, drn, hit;
    logic [31:0] waddr;
    logic [7:0]  be;
    logic [63:0] wd;
    if (reset) begin
      mcnt[k]  = 0;
      qerr[k]  = 1'b0;
      qerra[k] = '0;
      return;
    end
    lanes = lanes_of(k);
    nb    = 1 << st_size;
    off   = int'(st_addr % 32'(lanes));
    mis   = (nb > lanes) || ((off % nb) != 0);
    waddr = st_addr - 32'(off);
    be    = '0;
    wd    = '0;
    if (!mis) begin
      for (int b = 0; b < nb; b++) begin
        be[off+b]            = 1'b1;
        wd[8*(off+b) +: 8]   = st_data[8*b +: 8];
      end
    end
    acc = st_valid && (mcnt[k] < depth_of(k)) && !mis;
    drn = (mcnt[k] > 0) && mem_ready;
    if (acc) begin
      tl  = mcnt[k] - 1;
      hit = merge_of(k) && (mcnt[k] >= 2) && (qaddr[k][(tl < 0) ? 0 : tl] == waddr);
      if (hit) begin
        for (int l = 0; l < 8; l++) begin
          if (be[l]) begin
            qbe[k][tl][l]          = 1'b1;
            qdat[k][tl][8*l +: 8]  = wd[8*l +: 8];
          end
        end
      end else begin
        qaddr[k][mcnt[k]] = waddr;
        qbe[k][mcnt[k]]   = be;
        qdat[k][mcnt[k]]  = wd;
        mcnt[k]++;
      end
    end
    if (drn) begin
      for (int i = 0; i < 7; i++) begin
        qaddr[k][i] = qaddr[k][i+1];
        qbe[k][i]   = qbe[k][i+1];
        qdat[k][i]  = qdat[k][i+1];
      end
      mcnt[k]--;
    end
    qerr[k] = st_valid && mis;
    if (st_valid && mis) qerra[k] = st_addr;
  endtask

  task automatic compareAll();
    logic        o_rdy, o_mv, o_ae, e_mv;
    logic [31:0] o_ma, o_ea, e_ma;
    logic [63:0] o_md, e_md;
    logic [7:0]  o_be, e_be;
    int          o_cnt;
    for (int k = 0; k < 3; k++) begin
      case (k)
        0: begin o_rdy = rdy_a; o_mv = mv_a; o_ae = ae_a; o_ma = ma_a; o_ea = ea_a;
                 o_md = 64'(md_a); o_be = 8'(be_a); o_cnt = int'(cnt_a); end
        1: begin o_rdy = rdy_b; o_mv = mv_b; o_ae = ae_b; o_ma = ma_b; o_ea = ea_b;
                 o_md = 64'(md_b); o_be = 8'(be_b); o_cnt = int'(cnt_b); end
        default: begin o_rdy = rdy_c; o_mv = mv_c; o_ae = ae_c; o_ma = ma_c; o_ea = ea_c;
                 o_md = md_c; o_be = be_c; o_cnt = int'(cnt_c); end
      endcase
      e_mv = (mcnt[k] > 0);
      e_ma = e_mv ? qaddr[k][0] : '0;
      e_be = e_mv ? qbe[k][0]   : '0;
      e_md = e_mv ? qdat[k][0]  : '0;
      checkOutput($sformatf("count[%0d]", k),      64'(o_cnt), 64'(mcnt[k]));
      checkOutput($sformatf("st_ready[%0d]", k),   64'(o_rdy), 64'(mcnt[k] < depth_of(k)));
      checkOutput($sformatf("mem_valid[%0d]", k),  64'(o_mv),  64'(e_mv));
      checkOutput($sformatf("mem_addr[%0d]", k),   64'(o_ma),  64'(e_ma));
      checkOutput($sformatf("mem_byteen[%0d]", k), 64'(o_be),  64'(e_be));
      checkOutput($sformatf("mem_wdata[%0d]", k),  o_md,       e_md);
      checkOutput($sformatf("align_err[%0d]", k),  64'(o_ae),  64'(qerr[k]));
      checkOutput($sformatf("err_addr[%0d]", k),   64'(o_ea),  64'(qerra[k]));
    end
  endtask

  // Drive one cycle of inputs just after a falling edge, step the models,
  // then compare everything on the next falling edge.
  task automatic applyStimulus(input logic rst, input logic v, input logic [1:0] sz,
                               input logic [31:0] a, input logic [63:0] d, input logic mr);
    reset     = rst;
    st_valid  = v;
    st_size   = sz;
    st_addr   = a;
    st_data   = d;
    mem_ready = mr;
    for (int k = 0; k < 3; k++) model_step(k);
    @(posedge clk);
    @(negedge clk);
    compareAll();
  endtask

  task automatic idle(input logic mr);
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 64'h0, mr);
  endtask

  initial begin
    logic        rst, v, mr;
    logic [1:0]  sz;
    logic [31:0] a;
    int          pct;

    $display("[TB] start");
    applyStimulus(1'b1, 1'b0, 2'd0, 32'h0, 64'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 2'd0, 32'h0, 64'h0, 1'b0);
    checkOutput("reset_count", 64'(cnt_a), 64'd0);
    checkOutput("reset_mem_valid", 64'(mv_a), 64'd0);

    // Byte store into the top lane of an empty buffer.
    applyStimulus(1'b0, 1'b1, 2'd0, 32'h1003, 64'hAB, 1'b0);
    checkOutput("sb_mem_addr", 64'(ma_a), 64'h1000);
    checkOutput("sb_byteen", 64'(be_a), 64'b1000);
    checkOutput("sb_wdata", 64'(md_a), 64'hAB000000);
    checkOutput("sb_count", 64'(cnt_a), 64'd1);
    idle(1'b1);

    // Misaligned halfword: pulse for one cycle, address is held.
    applyStimulus(1'b0, 1'b1, 2'd1, 32'h2001, 64'h5555, 1'b0);
    checkOutput("mis_align_err", 64'(ae_a), 64'd1);
    checkOutput("mis_err_addr", 64'(ea_a), 64'h2001);
    checkOutput("mis_count", 64'(cnt_a), 64'd0);
    idle(1'b0);
    checkOutput("mis_pulse_end", 64'(ae_a), 64'd0);
    checkOutput("mis_err_hold", 64'(ea_a), 64'h2001);

    // Fill to full with memory stalled, then drain in order.
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 1'b1, 2'd2, 32'h10 + 32'(4*i), 64'(i + 1), 1'b0);
    checkOutput("full_count", 64'(cnt_a), 64'd4);
    checkOutput("full_ready", 64'(rdy_a), 64'd0);
    applyStimulus(1'b0, 1'b1, 2'd2, 32'h20, 64'h99, 1'b0);
    checkOutput("full_hold_count", 64'(cnt_a), 64'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput("drain_addr", 64'(ma_a), 64'h10 + 64'(4*i));
      idle(1'b1);
    end
    checkOutput("drain_count", 64'(cnt_a), 64'd0);
    idle(1'b1);
    idle(1'b1);

    // Accept and drain in the same cycle.
    applyStimulus(1'b0, 1'b1, 2'd2, 32'h40, 64'hA0, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'd2, 32'h44, 64'hA1, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'd2, 32'h48, 64'hA2, 1'b1);
    checkOutput("simul_count", 64'(cnt_a), 64'd2);
    checkOutput("simul_head", 64'(ma_a), 64'h44);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Merge sequence: merging instance folds the two bytes together.
    applyStimulus(1'b0, 1'b1, 2'd2, 32'h3000, 64'h11111111, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'd0, 32'h3004, 64'h22, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'd0, 32'h3005, 64'h33, 1'b0);
    checkOutput("merge_count", 64'(cnt_b), 64'd2);
    checkOutput("nomerge_count", 64'(cnt_a), 64'd3);
    idle(1'b1);
    checkOutput("merge_byteen", 64'(be_b), 64'b0011);
    checkOutput("merge_wdata", 64'(md_b), 64'h00003322);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // 64-bit doubleword stores, misalignment and reset mid-operation.
    applyStimulus(1'b1, 1'b0, 2'd0, 32'h0, 64'h0, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'd3, 32'h48, 64'h0123456789ABCDEF, 1'b0);
    checkOutput("sd_byteen", 64'(be_c), 64'hFF);
    applyStimulus(1'b0, 1'b1, 2'd3, 32'h44, 64'h1, 1'b0);
    checkOutput("sd_mis_err", 64'(ae_c), 64'd1);
    applyStimulus(1'b0, 1'b1, 2'd3, 32'h50, 64'h2, 1'b0);
    applyStimulus(1'b0, 1'b1, 2'd3, 32'h58, 64'h3, 1'b0);
    checkOutput("sd_count", 64'(cnt_c), 64'd3);
    applyStimulus(1'b1, 1'b0, 2'd0, 32'h0, 64'h0, 1'b0);
    checkOutput("rst_mid_count", 64'(cnt_c), 64'd0);
    checkOutput("rst_mid_valid", 64'(mv_c), 64'd0);
    checkOutput("rst_mid_erraddr", 64'(ea_c), 64'd0);

    // Random traffic in a small window so merges and fills are frequent.
    for (int n = 0; n < 1200; n++) begin
      pct = ((n % 200) < 100) ? 25 : 80;
      rst = ($urandom_range(0, 149) == 0);
      v   = ($urandom_range(0, 3) != 0);
      sz  = 2'($urandom_range(0, 3));
      a   = 32'h3000 + 32'($urandom_range(0, 23));
      mr  = ($urandom_range(0, 99) < pct);
      applyStimulus(rst, v, sz, a, {$urandom, $urandom}, mr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
